// File: rtl/song_pkg.sv
// Shared widths, reader state encoding and ROM word field helpers for the song sequencer.
// Pure declarations: no latency, no flow control.
package song_pkg;
    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int SONG_W   = 2;
    localparam int IDX_W    = 5;
    localparam int SONG_LEN = 32;
    localparam int WORD_W   = NOTE_W + DUR_W;
    localparam int ADDR_W   = SONG_W + IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } reader_state_t;

    function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
        return w[WORD_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
        return w[DUR_W-1:0];
    endfunction
endpackage

// File: rtl/note_timer.sv
// Beat down-counter for the current note; expire pulses combinationally on the last counted beat.
// Beats are counted only while en is high, so a paused or idle reader drops them.
module note_timer
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             beat,
    input  logic             en,
    output logic             expire
);
    logic [DUR_W-1:0] remaining_q, remaining_d;
    logic             tick;

    // Zero guard keeps the counter from wrapping if a beat ever lands with nothing loaded.
    assign tick   = en && beat && (remaining_q != '0);
    assign expire = tick && (remaining_q == DUR_W'(1));

    always_comb begin
        remaining_d = remaining_q;
        if (load) begin
            remaining_d = load_val;
        end else if (tick) begin
            remaining_d = remaining_q - DUR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end
endmodule

// File: rtl/song_reader.sv
// Walks a 32-entry song in ROM and hands each non-zero-duration note to the player (new_note 3 cycles after start).
// play low freezes the walk in place; a song change restarts fetching from entry 0 immediately.
module song_reader
    import song_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              beat,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_dout,
    output logic [NOTE_W-1:0] note,
    output logic [DUR_W-1:0]  duration,
    output logic              new_note,
    output logic              playing,
    output logic              song_done
);
    reader_state_t     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic              new_note_q, new_note_d;
    logic              song_chg, tmr_load, tmr_en, tmr_expire;

    assign song_chg = (state_q != ST_IDLE) && (song != song_q);
    assign tmr_en   = (state_q == ST_PLAY) && play && !song_chg;

    note_timer u_note_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (word_dur(rom_dout)),
        .beat     (beat),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        song_d     = song_q;
        note_d     = note_q;
        dur_d      = dur_q;
        new_note_d = 1'b0;
        tmr_load   = 1'b0;
        // A new selection overrides pause, beats and end-of-song handling.
        if (song_chg) begin
            song_d  = song;
            idx_d   = '0;
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d  = '0;
                    song_d = song;
                    if (play) state_d = ST_FETCH;
                end
                ST_FETCH: if (play) state_d = ST_LOAD;
                ST_LOAD: begin
                    if (play) begin
                        if (word_dur(rom_dout) == '0) begin
                            state_d = ST_NEXT;
                        end else begin
                            note_d     = word_note(rom_dout);
                            dur_d      = word_dur(rom_dout);
                            tmr_load   = 1'b1;
                            new_note_d = 1'b1;
                            state_d    = ST_PLAY;
                        end
                    end
                end
                ST_PLAY: if (tmr_expire) state_d = ST_NEXT;
                ST_NEXT: begin
                    if (play) begin
                        if (idx_q == IDX_W'(SONG_LEN - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            song_q     <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            new_note_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            song_q     <= song_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            new_note_q <= new_note_d;
        end
    end

    assign rom_addr  = {song_q, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = new_note_q;
    assign playing   = (state_q == ST_PLAY);
    assign song_done = (state_q == ST_DONE);
endmodule

// File: doc/song_reader.md
# song_reader

Sequencer between the song ROM and the note player. Walks the 32 entries of the selected song and fetches each 12-bit `{note, duration}` word through the ROM's one-cycle registered read. Presents each note to the note player with a one-cycle `new_note` strobe and holds it for `duration` beats, counted from the system `beat` tick. Skips zero-duration entries and reports end-of-song.

## Interface
- `NOTE_W`, 6, note index width; 0 = rest
- `DUR_W`, 6, duration width in beats
- `SONG_W`, 2, song-select width; 4 songs
- `IDX_W`, 5, note-index width; 32 entries per song
- `clk`  in  1  system clock; sole clock
- `reset`  in  1  synchronous, active-high
- `play`  in  1  level; high = run, low = pause in place
- `song`  in  SONG_W  song select, sampled continuously
- `beat`  in  1  one-cycle duration tick
- `rom_addr`  out  SONG_W+IDX_W  `{song_q, idx}` to ROM
- `rom_dout`  in  NOTE_W+DUR_W  ROM word, valid one cycle after `rom_addr`; `[11:6]` = note, `[5:0]` = duration
- `note`  out  NOTE_W  current note to the player
- `duration`  out  DUR_W  duration of the current note as loaded
- `new_note`  out  1  one-cycle pulse in the first PLAY cycle of each note
- `playing`  out  1  high while in PLAY
- `song_done`  out  1  one-cycle pulse after entry 31 completes

## Operation
- States: IDLE, FETCH, LOAD, PLAY, NEXT, DONE.
- `rom_addr` is combinational from `{song_q, idx}` and stable in every state.
- IDLE: `idx`=0, `song_q`<=`song`. If `play`=1, go to FETCH.
- FETCH: ROM address presented; go to LOAD.
- LOAD: `rom_dout` is valid.
  - If duration field = 0: go to NEXT. `note`, `duration` and `new_note` are unchanged.
  - Otherwise: register `note`, `duration` and `remaining`=duration; go to PLAY with `new_note`=1 in that first PLAY cycle.
- PLAY: on `beat`&`play`, `remaining` -= 1. When `beat`&`play` arrives with `remaining`=1, go to NEXT.
- NEXT: if `idx`=31, go to DONE; otherwise `idx`+=1 and go to FETCH.
- DONE: `song_done`=1 for one cycle; `idx`=0; go to IDLE. If `play` is still high, the song restarts, giving a loop.
- Note 0 (rest) is played like any other note, with `new_note` pulsed. The player silences on note 0.
- Pause: `play`=0 freezes FETCH, LOAD, PLAY and NEXT. Beats arriving while paused are dropped. Outputs hold. The ROM word stays valid because the address is constant.
- Song change: `song`≠`song_q` in any state other than IDLE → `song_q`<=`song`, `idx`=0, go to FETCH. `note` holds until the new first note loads. This takes priority over beat, pause and DONE.
- `remaining` is DUR_W bits and never underflows. A duration of 63 gives 63 beats.

## Timing
- Reset (synchronous, wins over all): state=IDLE, `idx`=0, `song_q`=0, `note`=0, `duration`=0, `remaining`=0, `new_note`=0, `playing`=0, `song_done`=0.
- Start: `play` rises in cycle t (IDLE) → FETCH at t+1, LOAD at t+2, PLAY with `new_note` at t+3.
- Note-to-note gap: the final beat is counted in cycle t → NEXT at t+1, FETCH at t+2, LOAD at t+3, next `new_note` at t+4. The previous `note` is held through the gap.
- Beats that fall outside PLAY are ignored. The `beat` period must be ≥ 8 cycles.
- Zero-duration entry: LOAD→NEXT→FETCH adds 3 cycles and produces no strobe.
- `song_done` is asserted one cycle after the NEXT that sees `idx`=31.

## Structure
- Package `song_pkg` holds the following:
  - NOTE_W, DUR_W, SONG_W and IDX_W.
  - SONG_LEN = 32.
  - The state enum `reader_state_t`.
  - Field-slice helpers for the ROM word.
- Sub-module `note_timer` is the duration down-counter:
  - Inputs: `load`, `load_val`, `beat`, `en`.
  - Output: `expire`, a one-cycle pulse when the last beat is counted.
- The FSM and address/index logic stay in `song_reader`.

## Test plan
- ROM model song 1, addr 32 = {35,36}. Reset, `song`=1, `play` high at t → `rom_addr`=32 at t+1; `new_note` at t+3 with `note`=35, `duration`=36. After exactly 36 beats, NEXT, and `rom_addr`=33 follows.
- Song 0 entries 28 and 29 = {37,0}, entry 30 = {0,0}, entry 31 = {x,4}. Run → no `new_note` for entries 28–30. Entry 31 plays for 4 beats, then `song_done` pulses once, `idx` returns to 0, and the song restarts if `play` is held.
- Drop `play` for 10 beats in the middle of a 9-beat note after 3 beats → `note` held, no NEXT. Resume → 6 more beats are needed to finish.
- Change `song` 1→2 during PLAY of entry 40 → FETCH of addr 64 the next cycle, `new_note` 3 cycles later. A coincident `beat` is ignored.
- Assert `reset` during PLAY with `beat`=1 in the same cycle → all outputs 0 and state IDLE the next cycle. No `new_note` or `song_done`.
- Beat pulse during the NEXT/FETCH/LOAD gap → dropped; the next note still lasts its full duration.
